// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned PROD_WIDTH = 2 * MULT_WIDTH;

endpackage

// File: rtl/mult32_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// Carries early_exit only when MULT_EARLY_EXIT_EN is defined.
interface mult32_seq_ctrl_if
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned PW    = PROD_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_p;
    logic             busy;
`ifdef MULT_EARLY_EXIT_EN
    logic             early_exit;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy, early_exit
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy, early_exit
    );
`else
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );
`endif
endinterface

// File: rtl/mult_seq_step.sv
// One shift-and-add iteration: conditional add of the shifted multiplicand,
// then advance multiplicand left and multiplier right.
module mult_seq_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);

    // Carry-out of the add is dropped; the full product always fits.
    always_comb begin
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
    end

endmodule

// File: rtl/mult32_seq_ctrl.sv
// Sequential shift-and-add multiplier controller: one adder reused over WIDTH
// cycles, valid/ready on both sides. Define MULT_EARLY_EXIT_EN to stop RUN as
// soon as the remaining multiplier bits are zero (adds the early_exit output).
module mult32_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input logic              clk,
    input logic              rst,
    mult32_seq_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    acc_q, mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    acc_nxt, mcand_nxt;
    logic [WIDTH-1:0] mplier_nxt;
    logic             accept;
`ifdef MULT_EARLY_EXIT_EN
    logic             early_q;
`endif

    assign accept = (state_q == StIdle) && bus.in_valid;

    mult_seq_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc       (acc_q),
        .mcand     (mcand_q),
        .mplier    (mplier_q),
        .acc_nxt   (acc_nxt),
        .mcand_nxt (mcand_nxt),
        .mplier_nxt(mplier_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
`ifdef MULT_EARLY_EXIT_EN
                    state_d = (bus.in_a == '0) ? StDone : StRun;
`else
                    state_d = StRun;
`endif
                end
            end
            StRun: begin
`ifdef MULT_EARLY_EXIT_EN
                if ((cnt_q == LastCnt) || (mplier_nxt == '0)) state_d = StDone;
`else
                if (cnt_q == LastCnt) state_d = StDone;
`endif
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand, accumulator and iteration counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`ifdef MULT_EARLY_EXIT_EN
            early_q  <= 1'b0;
`endif
        end else if (accept) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, bus.in_b};
            mplier_q <= bus.in_a;
            cnt_q    <= '0;
`ifdef MULT_EARLY_EXIT_EN
            early_q  <= (bus.in_a == '0);
`endif
        end else if (state_q == StRun) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_nxt;
            mplier_q <= mplier_nxt;
            cnt_q    <= cnt_q + CNT_W'(1);
`ifdef MULT_EARLY_EXIT_EN
            // Only the value from the final RUN step is observed in DONE.
            early_q  <= (cnt_q != LastCnt);
`endif
        end
    end

    // Handshake and result outputs decoded from state.
    always_comb begin
        bus.in_ready   = (state_q == StIdle);
        bus.out_valid  = (state_q == StDone);
        bus.busy       = (state_q != StIdle);
        bus.out_p      = (state_q == StDone) ? acc_q : '0;
`ifdef MULT_EARLY_EXIT_EN
        bus.early_exit = (state_q == StDone) && early_q;
`endif
    end

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Self-checking bench for mult32_seq_ctrl: transaction-level reference model
// compared every cycle, plus directed literal checks on products and latency.
module tb_mult32_seq_ctrl;
    import mult_pkg::*;

    localparam int W = 32;
`ifdef MULT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult32_seq_ctrl_if bus_if ();

    mult32_seq_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          chk_en      = 1'b0;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edges from accept until the product is presented.
    function automatic int lat_of(input logic [31:0] a);
        if (!EE) return W;
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i]) return i + 1;
        end
        return 0;
    endfunction

    // Reference model: one outstanding transaction, known product and latency.
    bit          m_busy = 1'b0;
    int          m_e    = 0;
    int          m_lat  = 0;
    logic [63:0] m_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (bus_if.in_valid) begin
                m_busy <= 1'b1;
                m_e    <= 0;
                m_lat  <= lat_of(bus_if.in_a);
                m_prod <= 64'(bus_if.in_a) * 64'(bus_if.in_b);
            end
        end else if (m_e >= m_lat && bus_if.out_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_e <= m_e + 1;
        end
    end

    bit mv;
    always @(negedge clk) begin
        if (chk_en) begin
            mv = m_busy && (m_e >= m_lat);
            check_bit("in_ready", bus_if.in_ready, !m_busy);
            check_bit("busy", bus_if.busy, m_busy);
            check_bit("out_valid", bus_if.out_valid, mv);
            check_val("out_p", bus_if.out_p, mv ? m_prod : 64'd0);
`ifdef MULT_EARLY_EXIT_EN
            check_bit("early_exit", bus_if.early_exit, mv && (m_lat < W));
`endif
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair and wait (bounded) for the product.
    task automatic accept_and_wait(input logic [31:0] a, input logic [31:0] b, output int n);
        bus_if.in_a      = a;
        bus_if.in_b      = b;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b0;
        check_bit("ready_before_accept", bus_if.in_ready, 1'b1);
        wait_edge();
        bus_if.in_valid = 1'b0;
        bus_if.in_a     = $urandom;
        bus_if.in_b     = $urandom;
        n = 0;
        while (!bus_if.out_valid && n < 200) begin
            wait_edge();
            n++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p,
                         input int lat);
        int n;
        accept_and_wait(a, b, n);
        check_val("latency", 64'(n), 64'(lat));
        check_val("product", bus_if.out_p, p);
`ifdef MULT_EARLY_EXIT_EN
        check_bit("early_exit_lit", bus_if.early_exit, lat < W);
`endif
        bus_if.out_ready = 1'b1;
        wait_edge();
        bus_if.out_ready = 1'b0;
        check_bit("idle_after_pop", bus_if.in_ready, 1'b1);
        check_bit("valid_after_pop", bus_if.out_valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        int    k;
        time   prev_t;
        time   acc_t;
        logic [31:0] ra;

        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.out_ready = 1'b0;
        wait_edge();
        wait_edge();
        chk_en = 1'b1;
        check_bit("rst_in_ready", bus_if.in_ready, 1'b1);
        check_bit("rst_out_valid", bus_if.out_valid, 1'b0);
        check_val("rst_out_p", bus_if.out_p, 64'd0);
        check_bit("rst_busy", bus_if.busy, 1'b0);
        rst = 1'b0;
        wait_edge();

        // Directed products with hand-computed results.
        do_op(32'd3, 32'd5, 64'd15, EE ? 2 : 32);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
        do_op(32'h8000_0000, 32'd2, 64'h1_0000_0000, 32);
        do_op(32'd0, 32'd99, 64'd0, EE ? 0 : 32);
        do_op(32'd5, 32'd9, 64'd45, EE ? 3 : 32);

        // Consumer stall with input noise.
        accept_and_wait(32'd7, 32'd6, n);
        check_val("stall_latency", 64'(n), 64'(EE ? 3 : 32));
        for (int i = 0; i < 10; i++) begin
            bus_if.in_valid = 1'($urandom_range(0, 1));
            bus_if.in_a     = $urandom;
            wait_edge();
            check_bit("stall_valid", bus_if.out_valid, 1'b1);
            check_val("stall_p", bus_if.out_p, 64'd42);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        wait_edge();
        bus_if.out_ready = 1'b0;
        check_bit("stall_release_idle", bus_if.in_ready, 1'b1);
        check_bit("stall_release_valid", bus_if.out_valid, 1'b0);

        // Reset in the middle of an operation discards it.
        bus_if.in_a     = 32'd1234;
        bus_if.in_b     = 32'd5678;
        bus_if.in_valid = 1'b1;
        wait_edge();
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < 15; i++) wait_edge();
        rst = 1'b1;
        wait_edge();
        rst = 1'b0;
        check_bit("midrst_in_ready", bus_if.in_ready, 1'b1);
        check_bit("midrst_out_valid", bus_if.out_valid, 1'b0);
        check_val("midrst_out_p", bus_if.out_p, 64'd0);
        check_bit("midrst_busy", bus_if.busy, 1'b0);
        do_op(32'd2, 32'd9, 64'd18, EE ? 2 : 32);

        // Back-to-back random traffic with the consumer always ready.
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        prev_t = 0;
        for (int i = 0; i < 100; i++) begin
            k = 0;
            while (!bus_if.in_ready && k < 100) begin
                wait_edge();
                k++;
            end
            if (k >= 100) check_bit("b2b_ready_timeout", bus_if.in_ready, 1'b1);
            if (i == 0) ra = 32'd0;
            else if (i == 1) ra = 32'h8000_0000;
            else if (i % 7 == 0) ra = 32'($urandom_range(0, 255));
            else ra = $urandom;
            bus_if.in_a = ra;
            bus_if.in_b = $urandom;
            @(posedge clk);
            acc_t = $time;
            if (!EE && i > 0) check_val("b2b_spacing", 64'((acc_t - prev_t) / 10), 64'd34);
            prev_t = acc_t;
            #1;
            bus_if.in_a = $urandom;
            bus_if.in_b = $urandom;
        end
        bus_if.in_valid = 1'b0;
        k = 0;
        while (bus_if.busy && k < 100) begin
            wait_edge();
            k++;
        end
        check_bit("drain_idle", bus_if.busy, 1'b0);
        bus_if.out_ready = 1'b0;
        wait_edge();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
